// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: CRC constants, broadcast address
// and the receive framer state encoding.
package modbus_pkg;

  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'hA001;
  localparam logic [7:0]  BCAST_ADDR = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_GAP,
    ST_HOLD,
    ST_DISCARD
  } rx_state_e;

endpackage

// File: rtl/modbus_rtu_frame_rx_if.sv
// Byte-in / frame-out bundle between the UART receive side,
// the RTU frame assembler and the register/command consumer.
interface modbus_rtu_frame_rx_if #(
  parameter int MAX_LEN = 256
);
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rx_drop_frame;
  logic          t35_done;
  logic          frame_valid;
  logic [8:0]    frame_len;
  logic          crc_ok;
  logic          addr_match;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_ovr;
  logic          err_gap;
  logic          err_clr;

  modport slave (
    input  rx_data, rx_done, rx_drop_frame, t35_done,
    input  frame_ack, rd_addr, err_clr,
    output frame_valid, frame_len, crc_ok, addr_match,
    output rd_data, err_ovr, err_gap
  );

  modport master (
    output rx_data, rx_done, rx_drop_frame, t35_done,
    output frame_ack, rd_addr, err_clr,
    input  frame_valid, frame_len, crc_ok, addr_match,
    input  rd_data, err_ovr, err_gap
  );

endinterface

// File: rtl/modbus_crc16_byte.sv
// Combinational CRC-16/MODBUS step: folds one byte into crc_in.
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU receive frame assembler: buffers bytes, checks CRC,
// enforces 1.5T/3.5T silence rules and holds the frame until acked.
module modbus_rtu_frame_rx
  import modbus_pkg::*;
#(
  parameter int          MAX_LEN    = 256,
  parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
  input logic clk,
  input logic rst,
  modbus_rtu_frame_rx_if.slave bus
);

  localparam int         AW   = $clog2(MAX_LEN);
  localparam logic [8:0] FULL = 9'(MAX_LEN);

  rx_state_e     state;
  logic [8:0]    cnt;
  logic [15:0]   crc;
  logic [15:0]   crc_base;
  logic [15:0]   crc_nxt;
  logic [7:0]    addr0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    mem [MAX_LEN];

  // A new frame always restarts from the init value.
  assign crc_base = (state == ST_IDLE) ? CRC_INIT : crc;

  modbus_crc16_byte u_crc (
    .crc_in  (crc_base),
    .data    (bus.rx_data),
    .crc_out (crc_nxt)
  );

  assign wr_en = bus.rx_done && !rst &&
                 ((state == ST_IDLE) ||
                  (state == ST_RECV && cnt != FULL));
  assign wr_addr = (state == ST_IDLE) ? '0 : cnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      crc             <= CRC_INIT;
      addr0           <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_len   <= '0;
      bus.crc_ok      <= 1'b0;
      bus.addr_match  <= 1'b0;
      bus.rd_data     <= '0;
      bus.err_ovr     <= 1'b0;
      bus.err_gap     <= 1'b0;
    end else begin
      bus.rd_data <= mem[bus.rd_addr];
      // Clear first so a same-cycle error event wins.
      if (bus.err_clr) begin
        bus.err_ovr <= 1'b0;
        bus.err_gap <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (bus.rx_done) begin
            cnt   <= 9'd1;
            crc   <= crc_nxt;
            addr0 <= bus.rx_data;
            state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (bus.rx_done) begin
            if (cnt == FULL) begin
              bus.err_ovr <= 1'b1;
              state       <= ST_DISCARD;
            end else begin
              cnt <= cnt + 9'd1;
              crc <= crc_nxt;
            end
          end else if (bus.rx_drop_frame) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (bus.rx_done) begin
            bus.err_gap <= 1'b1;
            state       <= ST_DISCARD;
          end else if (bus.t35_done) begin
            bus.frame_valid <= 1'b1;
            bus.frame_len   <= cnt;
            bus.crc_ok      <= (crc == 16'h0000) && (cnt >= 9'd4);
            bus.addr_match  <= (addr0 == SLAVE_ADDR) ||
                               (addr0 == BCAST_ADDR);
            state           <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.rx_done) bus.err_ovr <= 1'b1;
          if (bus.frame_ack) begin
            bus.frame_valid <= 1'b0;
            bus.frame_len   <= '0;
            bus.crc_ok      <= 1'b0;
            bus.addr_match  <= 1'b0;
            crc             <= CRC_INIT;
            state           <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (bus.t35_done) begin
            crc   <= CRC_INIT;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for the Modbus RTU frame assembler: fixed vectors, corner
// sequences and random frames checked against a bit-serial CRC model.
module tb_modbus_rtu_frame_rx;

  localparam int MAX_LEN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  modbus_rtu_frame_rx_if #(.MAX_LEN(MAX_LEN)) bus ();

  modbus_rtu_frame_rx #(
    .MAX_LEN    (MAX_LEN),
    .SLAVE_ADDR (8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int         n;
    logic [7:0] b [8];
    logic [8:0] len;
    logic       ok;
    logic       am;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic drp);
    bus.rx_data       = b;
    bus.rx_done       = 1'b1;
    bus.rx_drop_frame = drp;
    tick;
    bus.rx_done       = 1'b0;
    bus.rx_drop_frame = 1'b0;
    tick;
  endtask

  task pulse_drop;
    bus.rx_drop_frame = 1'b1;
    tick;
    bus.rx_drop_frame = 1'b0;
    tick;
  endtask

  task pulse_t35;
    bus.t35_done = 1'b1;
    tick;
    bus.t35_done = 1'b0;
  endtask

  task pulse_clr;
    bus.err_clr = 1'b1;
    tick;
    bus.err_clr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.rd_addr = a;
    tick;
    d = bus.rd_data;
  endtask

  task do_ack;
    bus.frame_ack = 1'b1;
    tick;
    bus.frame_ack = 1'b0;
  endtask

  // Reference CRC: the message as an LSB-first bit stream through a
  // reflected LFSR; a frame with its CRC appended leaves residual 0.
  function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic void add_crc(inout logic [7:0] q[$]);
    logic [15:0] c;
    c = ref_crc(q);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endfunction

  task automatic run_frame(input string nm, input logic [7:0] q[$],
                           input int drop_at, input logic [8:0] el,
                           input logic eo, input logic ea);
    logic [7:0] d;
    foreach (q[i]) send(q[i], i == drop_at);
    pulse_drop;
    chk({nm, ".valid_early"}, 32'(bus.frame_valid), 32'd0);
    pulse_t35;
    chk({nm, ".valid"}, 32'(bus.frame_valid), 32'd1);
    chk({nm, ".len"}, 32'(bus.frame_len), 32'(el));
    chk({nm, ".crc_ok"}, 32'(bus.crc_ok), 32'(eo));
    chk({nm, ".addr_match"}, 32'(bus.addr_match), 32'(ea));
    foreach (q[i]) begin
      rd(8'(i), d);
      chk($sformatf("%s.rd[%0d]", nm, i), 32'(d), 32'(q[i]));
    end
    chk({nm, ".valid_held"}, 32'(bus.frame_valid), 32'd1);
    do_ack;
    chk({nm, ".valid_ack"}, 32'(bus.frame_valid), 32'd0);
    tick;
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  d;
    logic [8:0]  el;
    logic        eo;
    logic        ea;
    int          seen;

    tbl[0].n = 8;
    tbl[0].b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    tbl[0].len = 9'd8; tbl[0].ok = 1'b1; tbl[0].am = 1'b1;
    tbl[1].n = 8;
    tbl[1].b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
    tbl[1].len = 9'd8; tbl[1].ok = 1'b0; tbl[1].am = 1'b1;
    tbl[2].n = 2;
    tbl[2].b = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].len = 9'd2; tbl[2].ok = 1'b0; tbl[2].am = 1'b1;
    tbl[3].n = 8;
    tbl[3].b = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    tbl[3].len = 9'd8; tbl[3].ok = 1'b0; tbl[3].am = 1'b0;
    tbl[4].n = 1;
    tbl[4].b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4].len = 9'd1; tbl[4].ok = 1'b0; tbl[4].am = 1'b1;

    bus.rx_data = '0; bus.rx_done = 1'b0; bus.rx_drop_frame = 1'b0;
    bus.t35_done = 1'b0; bus.frame_ack = 1'b0; bus.rd_addr = '0;
    bus.err_clr = 1'b0;
    tick; tick;
    chk("rst.valid", 32'(bus.frame_valid), 32'd0);
    chk("rst.len", 32'(bus.frame_len), 32'd0);
    chk("rst.crc_ok", 32'(bus.crc_ok), 32'd0);
    chk("rst.addr_match", 32'(bus.addr_match), 32'd0);
    chk("rst.rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst.err_ovr", 32'(bus.err_ovr), 32'd0);
    chk("rst.err_gap", 32'(bus.err_gap), 32'd0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 5; v++) begin
      q = {};
      for (int j = 0; j < tbl[v].n; j++) q.push_back(tbl[v].b[j]);
      run_frame($sformatf("vec%0d", v), q, -1,
                tbl[v].len, tbl[v].ok, tbl[v].am);
    end

    // Byte and 1.5T pulse together: byte kept, frame continues.
    q = {};
    for (int j = 0; j < 8; j++) q.push_back(tbl[0].b[j]);
    run_frame("drop_with_byte", q, 2, 9'd8, 1'b1, 1'b1);

    // Valid CRC but only 3 bytes: never crc_ok.
    q = {8'h01};
    add_crc(q);
    run_frame("short_good_crc", q, -1, 9'd3, 1'b0, 1'b1);
    q = {8'h00, 8'h11};
    add_crc(q);
    run_frame("min_good_crc", q, -1, 9'd4, 1'b1, 1'b1);

    // Byte between 1.5T and 3.5T gaps.
    for (int j = 0; j < 4; j++) send(tbl[0].b[j], 1'b0);
    pulse_drop;
    send(8'h42, 1'b0);
    chk("gap.err_gap", 32'(bus.err_gap), 32'd1);
    pulse_t35;
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.frame_valid) seen++;
      tick;
    end
    chk("gap.no_valid", 32'(seen), 32'd0);
    chk("gap.err_ovr", 32'(bus.err_ovr), 32'd0);
    pulse_clr;
    chk("gap.clr", 32'(bus.err_gap), 32'd0);
    q = {};
    for (int j = 0; j < 8; j++) q.push_back(tbl[0].b[j]);
    run_frame("after_gap", q, -1, 9'd8, 1'b1, 1'b1);

    // Exactly MAX_LEN bytes is a legal frame.
    q = {8'h01};
    for (int j = 1; j < MAX_LEN - 2; j++) q.push_back(8'($urandom));
    add_crc(q);
    run_frame("full256", q, -1, 9'd256, 1'b1, 1'b1);

    // One byte past MAX_LEN overflows and discards.
    for (int j = 0; j < MAX_LEN; j++) send(8'($urandom), 1'b0);
    chk("ovr.before", 32'(bus.err_ovr), 32'd0);
    send(8'h99, 1'b0);
    chk("ovr.set", 32'(bus.err_ovr), 32'd1);
    pulse_drop;
    pulse_t35;
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.frame_valid) seen++;
      tick;
    end
    chk("ovr.no_valid", 32'(seen), 32'd0);
    pulse_clr;
    chk("ovr.clr", 32'(bus.err_ovr), 32'd0);

    // Bytes while a frame is held.
    for (int j = 0; j < 8; j++) send(tbl[0].b[j], 1'b0);
    pulse_drop;
    pulse_t35;
    chk("hold.valid", 32'(bus.frame_valid), 32'd1);
    send(8'h55, 1'b0);
    chk("hold.err_ovr", 32'(bus.err_ovr), 32'd1);
    rd(8'd0, d);
    chk("hold.rd0", 32'(d), 32'h01);
    chk("hold.still_valid", 32'(bus.frame_valid), 32'd1);
    bus.err_clr = 1'b1; bus.rx_data = 8'h66; bus.rx_done = 1'b1;
    tick;
    bus.err_clr = 1'b0; bus.rx_done = 1'b0;
    chk("hold.set_wins", 32'(bus.err_ovr), 32'd1);
    pulse_clr;
    chk("hold.clr", 32'(bus.err_ovr), 32'd0);
    bus.frame_ack = 1'b1; bus.rx_data = 8'h77; bus.rx_done = 1'b1;
    tick;
    bus.frame_ack = 1'b0; bus.rx_done = 1'b0;
    chk("ack_byte.valid", 32'(bus.frame_valid), 32'd0);
    chk("ack_byte.err_ovr", 32'(bus.err_ovr), 32'd1);
    tick;
    pulse_clr;
    q = {};
    for (int j = 0; j < 8; j++) q.push_back(tbl[0].b[j]);
    run_frame("after_ack_byte", q, -1, 9'd8, 1'b1, 1'b1);

    // Reset in the middle of a frame.
    for (int j = 0; j < 3; j++) send(tbl[0].b[j], 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("midrst.valid", 32'(bus.frame_valid), 32'd0);
    chk("midrst.len", 32'(bus.frame_len), 32'd0);
    run_frame("after_rst", q, -1, 9'd8, 1'b1, 1'b1);

    // Random frames against the model.
    for (int r = 0; r < 12; r++) begin
      int nb;
      int sel;
      q = {};
      nb  = $urandom_range(1, 12);
      sel = $urandom_range(0, 2);
      q.push_back(sel == 0 ? 8'h01 : sel == 1 ? 8'h00 : 8'($urandom));
      for (int j = 1; j < nb; j++) q.push_back(8'($urandom));
      if ($urandom_range(0, 2) != 0) add_crc(q);
      el = 9'(q.size());
      eo = (ref_crc(q) == 16'h0000) && (q.size() >= 4);
      ea = (q[0] == 8'h01) || (q[0] == 8'h00);
      run_frame($sformatf("rand%0d", r), q, -1, el, eo, ea);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
